dmac_channel_gen2: RTL and testbench
====================================

// Module: dmac_channel_gen2
// PURPOSE
//  Parametrised second-generation single DMA channel: moves T_Size beats from source to destination as
//  alternating read bursts then write bursts over one AHB-Lite master port, buffered in an internal FIFO.
//  Adds to gen1: data width/FIFO depth params, per-side fixed/increment addressing, HRESP error abort, status.
//  Sits between the DMAC register block (config in) and the master-port mux (AHB out); one instance per channel.
// PARAMETERS
//  DATA_W      32  bus data width in bits; 8/16/32/64; address step = DATA_W/8
//  FIFO_DEPTH  8   beat buffer depth, power of 2, >=2; caps every burst length
//  CNT_W       32  width of transfer/burst counters
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  channel_en  in   1       level start/hold; deassert to acknowledge done/error
//  readyIn     in   1       HREADY from the slave; low stretches the current data phase
//  M_HResp     in   2       HRESP; 2'b00 OKAY, 2'b01 ERROR
//  S_Address   in   32      source start address, sampled on start
//  D_Address   in   32      destination start address, sampled on start
//  T_Size      in   CNT_W   total beats, sampled on start
//  B_Size      in   CNT_W   beats per burst, sampled on start; 0 treated as 1
//  src_incr    in   1       1: source address += DATA_W/8 per beat; 0: fixed (peripheral)
//  dst_incr    in   1       same for destination
//  R_Data      in   DATA_W  HRDATA
//  irq         out  1       done or error; held until channel_en low
//  err         out  1       transfer aborted by HRESP ERROR; held with irq
//  busy        out  1       high in any state except IDLE
//  write       out  1       HWRITE
//  HTrans      out  2       2'b00 IDLE, 2'b10 NONSEQ (first beat of burst), 2'b11 SEQ
//  MAddress    out  32      HADDR
//  MWData      out  DATA_W  HWDATA (FIFO head during write data phase)
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, all counters 0; irq/err/busy/write=0, HTrans=2'b00, MAddress/MWData=0.
//  FSM: IDLE -> RD -> WR -> (RD | DONE); any -> ERR on error; DONE/ERR -> IDLE when channel_en=0.
//  IDLE: channel_en=1 latches all config; T_Size=0 -> DONE next cycle (irq, no bus traffic), else RD.
//  burst len L = min(B_Size, remaining, FIFO_DEPTH), fixed at entry to RD.
//  RD: address phases back-to-back, NONSEQ then SEQ, write=0; next address only when readyIn=1.
//   data phase: R_Data pushed into FIFO when readyIn=1; after L-th beat's data accepted -> WR.
//  WR: same pipelining, write=1, MAddress from dst pointer; MWData = FIFO head, popped on readyIn=1.
//   after L-th data phase: remaining -= L; remaining=0 -> DONE else RD. Pointers persist across bursts.
//  HTrans=2'b00 in every cycle with no pending address phase (incl. last data phase of a burst).
//  Address held stable while readyIn=0; pointers wrap modulo 2^32, no boundary checks.
//  FIFO never overflows (L<=FIFO_DEPTH) and is empty at every RD entry.
//  ERR: M_HResp=2'b01 in a data phase -> HTrans=2'b00 next cycle, FIFO flushed, irq=err=1 until channel_en=0.
//  DONE: irq=1, err=0, busy=1 until channel_en=0. channel_en low mid-transfer is ignored (completes).
//  rst mid-transfer returns to reset state in one cycle; no bus phase completed.
// CONFIGURATION
//  DMAC_CH_ABORT_EN defined: extra input abort (1 bit). abort=1 in RD/WR -> finish in-flight data phase,
//   issue no new address, flush FIFO, go IDLE, irq=err=0 (silent stop). Undefined: no port, no logic.
// STRUCTURE
//  dmac_pkg: state enum (IDLE,RD,WR,DONE,ERR), HTRANS_*/HRESP_* localparams, min() function.
//  sub-module dmac_sync_fifo #(DATA_W, FIFO_DEPTH): push/pop/flush, full/empty, same-cycle push+pop legal.
// TESTING
//  1 S=0x100,D=0x200,T=8,B=4,incr both, readyIn=1 -> RD4,WR4,RD4,WR4; HADDR 0x100..0x10C,0x200..; irq after last write.
//  2 T=10,B=16,FIFO_DEPTH=8 -> bursts 8 then 2; second NONSEQ at src 0x120; D gets data in order.
//  3 src_incr=0,S=0x4000,T=3 -> all reads at 0x4000; dest addresses increment; data preserved.
//  4 readyIn low 3 cycles mid-write -> HADDR/HWDATA/HTrans stable; no beat lost/duplicated.
//  5 HRESP=2'b01 on read beat 2 -> HTrans=00 next cycle, irq=err=1 until channel_en=0, then IDLE.
//  6 T_Size=0 -> no NONSEQ ever; irq=1 one cycle after start; rst mid-RD -> all outputs reset next cycle.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared types and constants for the gen2 DMA channel: FSM state encoding,
// AHB-Lite transfer/response codes and a small min() helper.
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE,
        ST_ERR
    } dmac_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    function automatic logic [63:0] min(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dmac_sync_fifo.sv
// Beat buffer between the read and write bursts of a DMA channel.
// FIFO_DEPTH must be a power of two; push and pop may occur in the same cycle.
module dmac_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmac_channel_gen2.sv
// Single DMA channel: alternating AHB-Lite read and write bursts through a local FIFO.
// Optional DMAC_CH_ABORT_EN adds an 'abort' input for a silent drain-and-stop.
module dmac_channel_gen2
    import dmac_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              channel_en,
    input  logic              readyIn,
    input  logic [1:0]        M_HResp,
    input  logic [31:0]       S_Address,
    input  logic [31:0]       D_Address,
    input  logic [CNT_W-1:0]  T_Size,
    input  logic [CNT_W-1:0]  B_Size,
    input  logic              src_incr,
    input  logic              dst_incr,
    input  logic [DATA_W-1:0] R_Data,
`ifdef DMAC_CH_ABORT_EN
    input  logic              abort,
`endif
    output logic              irq,
    output logic              err,
    output logic              busy,
    output logic              write,
    output logic [1:0]        HTrans,
    output logic [31:0]       MAddress,
    output logic [DATA_W-1:0] MWData,
    output dmac_state_e       dbg_state
);

    localparam logic [31:0]      STEP    = 32'(DATA_W / 8);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    dmac_state_e      state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] b_cfg;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] addr_cnt;
    logic [CNT_W-1:0] data_cnt;
    logic             dphase;
    logic             src_inc_q;
    logic             dst_inc_q;

    logic             addr_act, addr_acc, resp_err, data_done, last_data, more_addr;
    logic             stop, abort_exit, xfer_state;
    logic [CNT_W-1:0] b_eff, rem_after, first_len, next_len;
    logic [31:0]      src_step, dst_step;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    function automatic logic [CNT_W-1:0] len_of(input logic [CNT_W-1:0] b,
                                                 input logic [CNT_W-1:0] r);
        return CNT_W'(min(min(64'(b), 64'(r)), 64'(DEPTH_C)));
    endfunction

    // readyIn=1 at a rising edge completes the current data phase (if any) and
    // accepts the current address phase (if any); readyIn=0 freezes both.
    assign xfer_state = (state == ST_RD) || (state == ST_WR);
    assign addr_act   = (HTrans != HTRANS_IDLE);
    assign addr_acc   = addr_act && readyIn;
    assign resp_err   = dphase && (M_HResp == HRESP_ERROR);
    assign data_done  = dphase && readyIn && !resp_err;
    assign last_data  = data_done && (data_cnt == burst_len - CNT_W'(1));
    assign more_addr  = (addr_cnt < burst_len) && !stop;
    assign b_eff      = (B_Size == '0) ? CNT_W'(1) : B_Size;
    assign rem_after  = remaining - burst_len;
    assign first_len  = len_of(b_eff, T_Size);
    assign next_len   = len_of(b_cfg, rem_after);
    assign src_step   = src_inc_q ? STEP : 32'h0;
    assign dst_step   = dst_inc_q ? STEP : 32'h0;

`ifdef DMAC_CH_ABORT_EN
    logic stop_q;
    assign stop       = stop_q || (abort && xfer_state);
    // Exit once nothing is left on the bus after this edge.
    assign abort_exit = stop && xfer_state && !resp_err && !addr_act && !(dphase && !readyIn);
`else
    assign stop       = 1'b0;
    assign abort_exit = 1'b0;
`endif

    assign fifo_push  = (state == ST_RD) && data_done && !fifo_full;
    assign fifo_pop   = (state == ST_WR) && data_done && !fifo_empty;
    assign fifo_flush = (xfer_state && resp_err) || abort_exit;

    assign MWData    = ((state == ST_WR) && dphase) ? fifo_rdata : '0;
    assign dbg_state = state;

    dmac_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (R_Data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            b_cfg     <= '0;
            burst_len <= '0;
            addr_cnt  <= '0;
            data_cnt  <= '0;
            dphase    <= 1'b0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            irq       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            write     <= 1'b0;
            HTrans    <= HTRANS_IDLE;
            MAddress  <= '0;
`ifdef DMAC_CH_ABORT_EN
            stop_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    HTrans <= HTRANS_IDLE;
                    write  <= 1'b0;
                    irq    <= 1'b0;
                    err    <= 1'b0;
                    busy   <= 1'b0;
                    dphase <= 1'b0;
                    if (channel_en) begin
                        remaining <= T_Size;
                        b_cfg     <= b_eff;
                        src_inc_q <= src_incr;
                        dst_inc_q <= dst_incr;
                        dst_ptr   <= D_Address;
                        src_ptr   <= S_Address;
                        busy      <= 1'b1;
                        if (T_Size == '0) begin
                            state <= ST_DONE;
                            irq   <= 1'b1;
                        end else begin
                            state     <= ST_RD;
                            burst_len <= first_len;
                            HTrans    <= HTRANS_NONSEQ;
                            MAddress  <= S_Address;
                            src_ptr   <= S_Address + (src_incr ? STEP : 32'h0);
                            addr_cnt  <= CNT_W'(1);
                            data_cnt  <= '0;
                        end
                    end
                end

                ST_RD, ST_WR: begin
                    if (resp_err) begin
                        state  <= ST_ERR;
                        HTrans <= HTRANS_IDLE;
                        dphase <= 1'b0;
                        write  <= 1'b0;
                        irq    <= 1'b1;
                        err    <= 1'b1;
`ifdef DMAC_CH_ABORT_EN
                        stop_q <= 1'b0;
`endif
                    end else begin
`ifdef DMAC_CH_ABORT_EN
                        if (stop) stop_q <= 1'b1;
`endif
                        if (addr_acc) begin
                            dphase <= 1'b1;
                            if (more_addr) begin
                                HTrans   <= HTRANS_SEQ;
                                addr_cnt <= addr_cnt + CNT_W'(1);
                                if (state == ST_RD) begin
                                    MAddress <= src_ptr;
                                    src_ptr  <= src_ptr + src_step;
                                end else begin
                                    MAddress <= dst_ptr;
                                    dst_ptr  <= dst_ptr + dst_step;
                                end
                            end else begin
                                HTrans <= HTRANS_IDLE;
                            end
                        end else if (data_done) begin
                            dphase <= 1'b0;
                        end

                        if (data_done) data_cnt <= data_cnt + CNT_W'(1);

                        // The last data phase never overlaps an address phase,
                        // so the next burst can start straight from here.
                        if (last_data) begin
                            data_cnt <= '0;
                            addr_cnt <= CNT_W'(1);
                            dphase   <= 1'b0;
                            if (state == ST_RD) begin
                                state    <= ST_WR;
                                write    <= 1'b1;
                                HTrans   <= HTRANS_NONSEQ;
                                MAddress <= dst_ptr;
                                dst_ptr  <= dst_ptr + dst_step;
                            end else begin
                                remaining <= rem_after;
                                write     <= 1'b0;
                                if (rem_after == '0) begin
                                    state  <= ST_DONE;
                                    HTrans <= HTRANS_IDLE;
                                    irq    <= 1'b1;
                                end else begin
                                    state     <= ST_RD;
                                    burst_len <= next_len;
                                    HTrans    <= HTRANS_NONSEQ;
                                    MAddress  <= src_ptr;
                                    src_ptr   <= src_ptr + src_step;
                                end
                            end
                        end

                        if (abort_exit) begin
                            state  <= ST_IDLE;
                            HTrans <= HTRANS_IDLE;
                            dphase <= 1'b0;
                            write  <= 1'b0;
                            irq    <= 1'b0;
                            busy   <= 1'b0;
`ifdef DMAC_CH_ABORT_EN
                            stop_q <= 1'b0;
`endif
                        end
                    end
                end

                ST_DONE, ST_ERR: begin
                    HTrans <= HTRANS_IDLE;
                    write  <= 1'b0;
                    if (!channel_en) begin
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_channel_gen2.sv
// Bench for dmac_channel_gen2: a table of transfer configurations run against an
// AHB-Lite slave model, plus directed sequences for T_Size=0 and mid-transfer reset.
`timescale 1ns/1ps
module tb_dmac_channel_gen2;
    import dmac_pkg::*;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              channel_en = 1'b0;
    logic              readyIn = 1'b1;
    logic [1:0]        M_HResp = HRESP_OKAY;
    logic [31:0]       S_Address = '0;
    logic [31:0]       D_Address = '0;
    logic [CNT_W-1:0]  T_Size = '0;
    logic [CNT_W-1:0]  B_Size = '0;
    logic              src_incr = 1'b1;
    logic              dst_incr = 1'b1;
    logic [DATA_W-1:0] R_Data = '0;
    logic              irq, err, busy, write;
    logic [1:0]        HTrans;
    logic [31:0]       MAddress;
    logic [DATA_W-1:0] MWData;
    dmac_state_e       dbg_state;
`ifdef DMAC_CH_ABORT_EN
    logic              abort = 1'b0;
`endif

    dmac_channel_gen2 #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .channel_en (channel_en),
        .readyIn    (readyIn),
        .M_HResp    (M_HResp),
        .S_Address  (S_Address),
        .D_Address  (D_Address),
        .T_Size     (T_Size),
        .B_Size     (B_Size),
        .src_incr   (src_incr),
        .dst_incr   (dst_incr),
        .R_Data     (R_Data),
`ifdef DMAC_CH_ABORT_EN
        .abort      (abort),
`endif
        .irq        (irq),
        .err        (err),
        .busy       (busy),
        .write      (write),
        .HTrans     (HTrans),
        .MAddress   (MAddress),
        .MWData     (MWData),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        int          t;
        int          b;
        bit          si;
        bit          di;
        int          stall;      // 0 always ready, 1 random wait states, 2 one 3-cycle stall mid-write
        int          err_beat;   // 0 none, n: ERROR response on the n-th read data phase
        int          exp_bursts;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int rd_iss, wr_iss, rd_done, wr_done, rd_left, wr_left, rd_ns, wr_ns;
        int stall_left, beff;
        bit dp_v, dp_w, stalled, prev_rdy, hit_irq, rdy, inj;
        logic [1:0]  prev_tr;
        logic [31:0] prev_addr, prev_wd, exp_addr;

        exp_q.delete();
        rd_iss = 0; wr_iss = 0; rd_done = 0; wr_done = 0;
        rd_left = 0; wr_left = 0; rd_ns = 0; wr_ns = 0;
        stall_left = 0; dp_v = 0; dp_w = 0; stalled = 0; prev_rdy = 1; hit_irq = 0;
        prev_tr = HTRANS_IDLE; prev_addr = '0; prev_wd = '0;
        beff = (v.b == 0) ? 1 : v.b;

        @(negedge clk);
        S_Address  = v.s;
        D_Address  = v.d;
        T_Size     = 32'(v.t);
        B_Size     = 32'(v.b);
        src_incr   = v.si;
        dst_incr   = v.di;
        readyIn    = 1'b1;
        M_HResp    = HRESP_OKAY;
        channel_en = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!prev_rdy && prev_tr != HTRANS_IDLE) begin
                check("stall_haddr", MAddress, prev_addr);
                check("stall_htrans", HTrans, prev_tr);
            end
            if (!prev_rdy && dp_v && dp_w) check("stall_hwdata", MWData, prev_wd);
            if (irq) begin
                hit_irq = 1;
                break;
            end

            rdy = 1;
            if (v.stall == 1) rdy = ($urandom_range(0, 3) != 0);
            if (v.stall == 2) begin
                if (stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else if (!stalled && dp_v && dp_w && wr_done == 1) begin
                    stalled = 1;
                    stall_left = 2;
                    rdy = 0;
                end
            end
            inj = (v.err_beat != 0) && dp_v && !dp_w && (rd_done == v.err_beat - 1);
            if (inj) rdy = 1;
            readyIn = rdy;
            M_HResp = inj ? HRESP_ERROR : HRESP_OKAY;
            R_Data  = (dp_v && !dp_w) ? {8'(id), 8'hA5, 16'(rd_done)} : 32'hDEAD_BEEF;

            if (rdy && !inj) begin
                if (dp_v) begin
                    if (dp_w) begin
                        if (exp_q.size() == 0) check("wdata_underrun", 64'd1, 64'd0);
                        else check("hwdata", MWData, exp_q.pop_front());
                        wr_done++;
                    end else begin
                        exp_q.push_back(R_Data);
                        rd_done++;
                    end
                end
                dp_v = 0;
                if (HTrans != HTRANS_IDLE) begin
                    dp_v = 1;
                    dp_w = write;
                    if (!write) begin
                        check("rd_within_total", 64'(rd_iss < v.t), 64'd1);
                        if (rd_left == 0) begin
                            check("rd_nonseq", HTrans, HTRANS_NONSEQ);
                            check("fifo_empty_at_rd", rd_done, wr_done);
                            rd_left = min3(beff, v.t - rd_iss, FIFO_DEPTH);
                            rd_ns++;
                        end else begin
                            check("rd_seq", HTrans, HTRANS_SEQ);
                        end
                        exp_addr = v.s + (v.si ? 32'(4 * rd_iss) : 32'h0);
                        check("rd_haddr", MAddress, exp_addr);
                        rd_iss++;
                        rd_left--;
                    end else begin
                        check("wr_within_total", 64'(wr_iss < v.t), 64'd1);
                        if (wr_left == 0) begin
                            check("wr_nonseq", HTrans, HTRANS_NONSEQ);
                            wr_left = min3(beff, v.t - wr_iss, FIFO_DEPTH);
                            check("burst_buffered", rd_done - wr_done, wr_left);
                            wr_ns++;
                        end else begin
                            check("wr_seq", HTrans, HTRANS_SEQ);
                        end
                        exp_addr = v.d + (v.di ? 32'(4 * wr_iss) : 32'h0);
                        check("wr_haddr", MAddress, exp_addr);
                        wr_iss++;
                        wr_left--;
                    end
                end
            end
            prev_rdy  = rdy;
            prev_tr   = HTrans;
            prev_addr = MAddress;
            prev_wd   = MWData;
        end

        check("irq_reached", hit_irq, 1);
        if (v.err_beat != 0) begin
            check("err_flag", err, 1);
            check("reads_before_err", rd_done, v.err_beat - 1);
            check("writes_before_err", wr_done, 0);
            check("dbg_err", dbg_state, ST_ERR);
        end else begin
            check("err_flag", err, 0);
            check("reads_total", rd_done, v.t);
            check("writes_total", wr_done, v.t);
            check("rd_bursts", rd_ns, v.exp_bursts);
            check("wr_bursts", wr_ns, v.exp_bursts);
            check("queue_drained", exp_q.size(), 0);
            check("dbg_done", dbg_state, ST_DONE);
        end
        check("htrans_idle_at_irq", HTrans, HTRANS_IDLE);
        check("busy_at_irq", busy, 1);

        readyIn = 1'b1;
        M_HResp = HRESP_OKAY;
        repeat (2) @(negedge clk);
        check("irq_held", irq, 1);
        check("htrans_held_idle", HTrans, HTRANS_IDLE);
        channel_en = 1'b0;
        @(negedge clk);
        check("irq_cleared", irq, 0);
        check("err_cleared", err, 0);
        check("busy_cleared", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 8,  4,  1'b1, 1'b1, 0, 0, 2};
        vecs[1] = '{32'h0000_0100, 32'h0000_0200, 10, 16, 1'b1, 1'b1, 0, 0, 2};
        vecs[2] = '{32'h0000_4000, 32'h0000_5000, 3,  4,  1'b0, 1'b1, 0, 0, 1};
        vecs[3] = '{32'h0000_0300, 32'h0000_0600, 6,  3,  1'b1, 1'b1, 2, 0, 2};
        vecs[4] = '{32'h0000_0010, 32'h0000_0020, 3,  0,  1'b1, 1'b1, 0, 0, 3};
        vecs[5] = '{32'hFFFF_FFF8, 32'h0000_0800, 5,  2,  1'b1, 1'b1, 1, 0, 3};
        vecs[6] = '{32'h0000_1000, 32'h0000_9000, 9,  8,  1'b1, 1'b0, 1, 0, 2};
        vecs[7] = '{32'h0000_0100, 32'h0000_0200, 8,  4,  1'b1, 1'b1, 0, 2, 0};

        repeat (3) @(negedge clk);
        check("reset_ctrl", {irq, err, busy, write, HTrans}, 6'b0);
        check("reset_haddr", MAddress, 32'h0);
        check("reset_hwdata", MWData, 32'h0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Zero-length transfer: straight to DONE, no bus traffic.
        @(negedge clk);
        S_Address = 32'h100; D_Address = 32'h200;
        T_Size = 32'd0; B_Size = 32'd4;
        channel_en = 1'b1;
        @(negedge clk);
        check("t0_irq", irq, 1);
        check("t0_busy", busy, 1);
        check("t0_err", err, 0);
        check("t0_state", dbg_state, ST_DONE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t0_no_traffic", HTrans, HTRANS_IDLE);
        end
        channel_en = 1'b0;
        @(negedge clk);
        check("t0_idle", busy, 0);

        // Reset in the middle of a read burst.
        S_Address = 32'h100; D_Address = 32'h200;
        T_Size = 32'd8; B_Size = 32'd4;
        readyIn = 1'b1;
        channel_en = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_state", dbg_state, ST_RD);
        check("pre_rst_htrans", HTrans, HTRANS_SEQ);
        check("pre_rst_haddr", MAddress, 32'h108);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {irq, err, busy, write, HTrans}, 6'b0);
        check("rst_mid_haddr", MAddress, 32'h0);
        check("rst_mid_hwdata", MWData, 32'h0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        channel_en = 1'b0;
        @(negedge clk);

        run_vec(9, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
